// File: rtl/serial_nibble_div6.sv
// Serial MSB-first nibble assembler with a running mod-6 remainder FSM.
// Emits each completed nibble, its divisible-by-6 flag and a saturating hit count.
module serial_nibble_div6 (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clear,
    output logic [3:0] nibble,
    output logic       nibble_valid,
    output logic       div6,
    output logic [2:0] rem,
    output logic [7:0] hit_count
);

    typedef enum logic [2:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4,
        R5 = 3'd5
    } rem_state_t;

    rem_state_t state_reg;
    rem_state_t state_next;
    rem_state_t step_state;
    logic [1:0] cnt_reg;
    logic [3:0] shift_reg;
    logic [3:0] nibble_reg;
    logic       nibble_valid_reg;
    logic       div6_reg;
    logic [7:0] hit_count_reg;
    logic       last_bit;

    assign last_bit = (cnt_reg == 2'd3);

    // (2*state + bit_in) mod 6 for the bit currently presented.
    always_comb begin
        step_state = R0;
        case (state_reg)
            R0: step_state = bit_in ? R1 : R0;
            R1: step_state = bit_in ? R3 : R2;
            R2: step_state = bit_in ? R5 : R4;
            R3: step_state = bit_in ? R1 : R0;
            R4: step_state = bit_in ? R3 : R2;
            R5: step_state = bit_in ? R5 : R4;
            default: step_state = R0;
        endcase
    end

    // Clear wins over bit_valid; a completed nibble restarts the FSM in R0.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = R0;
        end else if (bit_valid) begin
            state_next = last_bit ? R0 : step_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= R0;
            cnt_reg          <= 2'd0;
            shift_reg        <= 4'd0;
            nibble_reg       <= 4'd0;
            nibble_valid_reg <= 1'b0;
            div6_reg         <= 1'b0;
            hit_count_reg    <= 8'd0;
        end else begin
            state_reg        <= state_next;
            nibble_valid_reg <= 1'b0;
            if (clear) begin
                cnt_reg <= 2'd0;
            end else if (bit_valid) begin
                shift_reg <= {shift_reg[2:0], bit_in};
                cnt_reg   <= cnt_reg + 2'd1;
                if (last_bit) begin
                    nibble_reg       <= {shift_reg[2:0], bit_in};
                    div6_reg         <= (step_state == R0);
                    nibble_valid_reg <= 1'b1;
                    if ((step_state == R0) && (hit_count_reg != 8'hFF)) begin
                        hit_count_reg <= hit_count_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign nibble       = nibble_reg;
    assign nibble_valid = nibble_valid_reg;
    assign div6         = div6_reg;
    assign rem          = state_reg;
    assign hit_count    = hit_count_reg;

endmodule

// File: tb/tb_serial_nibble_div6.sv
// Randomized bench for serial_nibble_div6: arithmetic reference model feeds a
// scoreboard queue that a negedge monitor drains on every nibble_valid pulse.
module tb_serial_nibble_div6;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic [3:0] nibble;
    logic       nibble_valid;
    logic       div6;
    logic [2:0] rem;
    logic [7:0] hit_count;

    serial_nibble_div6 dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .clear        (clear),
        .nibble       (nibble),
        .nibble_valid (nibble_valid),
        .div6         (div6),
        .rem          (rem),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nib;
        int d;
        int hc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: the partial nibble as an integer plus the bit count.
    int part_val  = 0;
    int part_cnt  = 0;
    int hits      = 0;
    int last_nib  = 0;
    int last_div  = 0;
    int exp_vld   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input bit r, input bit v, input bit b, input bit c);
        exp_t e;
        reset     = r;
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        exp_vld   = 0;
        if (r) begin
            part_val = 0;
            part_cnt = 0;
            hits     = 0;
            last_nib = 0;
            last_div = 0;
        end else if (c) begin
            part_val = 0;
            part_cnt = 0;
        end else if (v) begin
            part_val = part_val * 2 + int'(b);
            part_cnt++;
            if (part_cnt == 4) begin
                last_nib = part_val;
                last_div = (part_val % 6 == 0) ? 1 : 0;
                if (last_div == 1 && hits < 255) hits++;
                exp_vld = 1;
                e.nib = last_nib;
                e.d   = last_div;
                e.hc  = hits;
                exp_q.push_back(e);
                part_val = 0;
                part_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        check("rem", int'(rem), part_val % 6);
        check("nibble_valid", int'(nibble_valid), exp_vld);
        check("nibble_hold", int'(nibble), last_nib);
        check("div6_hold", int'(div6), last_div);
        check("hit_count", int'(hit_count), hits);
    endtask

    task automatic send_nibble(input int val, input int gap_max);
        for (int i = 3; i >= 0; i--) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cyc(1'b0, 1'b1, val[i], 1'b0);
        end
    endtask

    // Monitor: every pulse must match the oldest expected nibble.
    always @(negedge clk) begin
        if (nibble_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got nibble=%0d expected no pulse at t=%0t", nibble, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_nibble", int'(nibble), e.nib);
                check("sb_div6", int'(div6), e.d);
                check("sb_hit_count", int'(hit_count), e.hc);
                check("sb_div6_vs_checker", int'(div6), (int'(nibble) % 6 == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Directed nibbles: 6, 9, 12 back to back.
        send_nibble(6, 0);
        send_nibble(9, 0);
        send_nibble(12, 0);
        // Same nibble with idle gaps between bits.
        send_nibble(6, 3);
        // Partial nibble dropped by reset, then by clear, then by clear+valid.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send_nibble(0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_nibble(0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        send_nibble(0, 1);
        // Eight consecutive bits: 6 then 5.
        send_nibble(6, 0);
        send_nibble(5, 0);

        // Random traffic with occasional clear and reset.
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
        end

        // Saturation: 260 zero nibbles.
        for (int n = 0; n < 260; n++) send_nibble(0, 0);
        check("hit_count_saturated", int'(hit_count), 255);
        send_nibble(0, 0);
        send_nibble(7, 0);

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
